// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: md_op encoding,
// default latencies (also used by the hazard unit) and FSM state type.
package mult_div_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/readback bundle between the EX-stage issue logic and the
// multiply/divide unit.
interface mult_div_unit_if;

  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        hilo_sel;
  logic        busy;
  logic [31:0] HiLoData;

  modport master (
    output start, md_op, A, B, hilo_sel,
    input  busy, HiLoData
  );

  modport slave (
    input  start, md_op, A, B, hilo_sel,
    output busy, HiLoData
  );

endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. The result is
// computed at accept time and parked in hi_nxt/lo_nxt; a down-counter
// models the latency before it is committed to HI/LO.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES)) + 1;

  md_state_e        state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [31:0]      hi, hi_d, lo, lo_d;
  logic [31:0]      hi_nxt, hi_nxt_d, lo_nxt, lo_nxt_d;

  logic [63:0]        prod_s, prod_u;
  logic               div_zero, div_ovf;
  logic signed [31:0] a_s, b_safe_s, q_s, r_s;
  logic [31:0]        b_safe_u, q_u, r_u;

  // Sign-extended 64-bit multiply gives the exact signed product in the low 64 bits.
  assign prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
  assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};

  // Divisor is forced to 1 for the zero and INT_MIN/-1 cases so the
  // divider never sees an undefined operation; those cases are patched below.
  assign div_zero = (bus.B == 32'd0);
  assign div_ovf  = (bus.A == 32'h8000_0000) && (bus.B == 32'hFFFF_FFFF);
  assign a_s      = $signed(bus.A);
  assign b_safe_s = (div_zero || div_ovf) ? 32'sd1 : $signed(bus.B);
  assign b_safe_u = div_zero ? 32'd1 : bus.B;
  assign q_s      = a_s / b_safe_s;
  assign r_s      = a_s % b_safe_s;
  assign q_u      = bus.A / b_safe_u;
  assign r_u      = bus.A % b_safe_u;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      hi_nxt <= '0;
      lo_nxt <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      hi     <= hi_d;
      lo     <= lo_d;
      hi_nxt <= hi_nxt_d;
      lo_nxt <= lo_nxt_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    hi_d     = hi;
    lo_d     = lo;
    hi_nxt_d = hi_nxt;
    lo_nxt_d = lo_nxt;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          case (bus.md_op)
            MD_MULT: begin
              hi_nxt_d = prod_s[63:32];
              lo_nxt_d = prod_s[31:0];
              cnt_d    = CNT_W'(MULT_CYCLES);
              state_d  = ST_BUSY;
            end
            MD_MULTU: begin
              hi_nxt_d = prod_u[63:32];
              lo_nxt_d = prod_u[31:0];
              cnt_d    = CNT_W'(MULT_CYCLES);
              state_d  = ST_BUSY;
            end
            MD_DIV: begin
              if (div_zero) begin
                hi_nxt_d = hi;
                lo_nxt_d = lo;
              end else if (div_ovf) begin
                hi_nxt_d = 32'd0;
                lo_nxt_d = 32'h8000_0000;
              end else begin
                hi_nxt_d = r_s;
                lo_nxt_d = q_s;
              end
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = ST_BUSY;
            end
            MD_DIVU: begin
              if (div_zero) begin
                hi_nxt_d = hi;
                lo_nxt_d = lo;
              end else begin
                hi_nxt_d = r_u;
                lo_nxt_d = q_u;
              end
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = ST_BUSY;
            end
            MD_MTHI: hi_d = bus.A;
            MD_MTLO: lo_d = bus.A;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        if (cnt == CNT_W'(1)) begin
          hi_d    = hi_nxt;
          lo_d    = lo_nxt;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy     = (state == ST_BUSY);
  assign bus.HiLoData = bus.hilo_sel ? hi : lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, HI/LO results, divide-by-zero,
// ignored requests while busy, and asynchronous reset mid-operation.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  mult_div_unit_if ifc ();

  mult_div_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called mid-cycle: the request is accepted at the next rising edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    ifc.start = 1'b1;
    ifc.md_op = op;
    ifc.A     = a;
    ifc.B     = b;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
  endtask

  task automatic read_hl(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    ifc.hilo_sel = 1'b1;
    #1;
    check({tag, "_hi"}, ifc.HiLoData, exp_hi);
    ifc.hilo_sel = 1'b0;
    #1;
    check({tag, "_lo"}, ifc.HiLoData, exp_lo);
    ifc.hilo_sel = 1'b1;
  endtask

  // Expects busy for exactly n cycles with the old HI still visible, then idle.
  task automatic run_busy(input string tag, input int n, input logic [31:0] old_hi);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "_busy"}, {31'd0, ifc.busy}, 32'd1);
      check({tag, "_old_hi"}, ifc.HiLoData, old_hi);
    end
    @(negedge clk);
    check({tag, "_done"}, {31'd0, ifc.busy}, 32'd0);
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    reset        = 1'b0;
    ifc.start    = 1'b0;
    ifc.md_op    = MD_MULT;
    ifc.A        = 32'd0;
    ifc.B        = 32'd0;
    ifc.hilo_sel = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, ifc.busy}, 32'd0);
    read_hl("rst", 32'd0, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    read_hl("post_rst", 32'd0, 32'd0);

    issue(MD_MULT, 32'hFFFF_FFFF, 32'd2);
    run_busy("mult", 5, 32'd0);
    read_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    // Back-to-back: issued in the first idle cycle after completion.
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    run_busy("multu", 5, 32'hFFFF_FFFF);
    read_hl("multu", 32'h0000_0001, 32'hFFFF_FFFE);

    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    run_busy("div", 10, 32'h0000_0001);
    read_hl("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(MD_DIVU, 32'd7, 32'd2);
    run_busy("divu", 10, 32'hFFFF_FFFF);
    read_hl("divu", 32'd1, 32'd3);

    issue(MD_MTLO, 32'd0, 32'd0);
    @(negedge clk);
    issue(MD_MTHI, 32'h1234_5678, 32'd0);
    @(negedge clk);
    check("mthi_busy", {31'd0, ifc.busy}, 32'd0);
    read_hl("mthi", 32'h1234_5678, 32'd0);

    issue(MD_DIV, 32'd55, 32'd0);
    run_busy("div0", 10, 32'h1234_5678);
    read_hl("div0", 32'h1234_5678, 32'd0);

    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_busy("div_ovf", 10, 32'h1234_5678);
    read_hl("div_ovf", 32'd0, 32'h8000_0000);

    issue(MD_DIVU, 32'd5, 32'd0);
    run_busy("divu0", 10, 32'd0);
    read_hl("divu0", 32'd0, 32'h8000_0000);

    // MULT 3*4 with a DIVU 100/3 request in its second busy cycle.
    issue(MD_MULT, 32'd3, 32'd4);
    @(negedge clk);
    check("ign_c1_busy", {31'd0, ifc.busy}, 32'd1);
    @(posedge clk);
    #1;
    issue(MD_DIVU, 32'd100, 32'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ign_busy", {31'd0, ifc.busy}, 32'd1);
    end
    @(negedge clk);
    check("ign_done", {31'd0, ifc.busy}, 32'd0);
    read_hl("ign", 32'd0, 32'd12);
    @(negedge clk);
    check("ign_no_restart", {31'd0, ifc.busy}, 32'd0);

    issue(3'd7, 32'hDEAD_BEEF, 32'd1);
    @(negedge clk);
    check("undef_busy", {31'd0, ifc.busy}, 32'd0);
    read_hl("undef", 32'd0, 32'd12);

    issue(MD_MTHI, 32'hCAFE_0001, 32'd0);
    issue(MD_DIV, 32'd100, 32'd7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_busy", {31'd0, ifc.busy}, 32'd1);
    end
    reset = 1'b0;
    #1;
    check("rst_mid_busy_clr", {31'd0, ifc.busy}, 32'd0);
    read_hl("rst_mid", 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_rel_busy", {31'd0, ifc.busy}, 32'd0);
    issue(MD_MTLO, 32'hA5A5_A5A5, 32'd0);
    @(negedge clk);
    read_hl("mtlo", 32'd0, 32'hA5A5_A5A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

- Multi-cycle multiply/divide unit with its HI and LO registers, in the EX stage of the P6 pipeline.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Presents HI or LO on a read port that feeds the ALU-result path into write-back, so MFHI/MFLO results reach the register-data selector.
- Drives `busy` so the hazard unit can stall dependent instructions.

## Interface

- MULT_CYCLES, default 5, number of busy cycles for MULT/MULTU.
- DIV_CYCLES, default 10, number of busy cycles for DIV/DIVU.

- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low; one clock, reset is asynchronous and active-low.
- start  input  1  request to execute `md_op` this cycle.
- md_op  input  3  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- A  input  32  rs operand (dividend / multiplicand / MTHI-MTLO source).
- B  input  32  rt operand (divisor / multiplier).
- hilo_sel  input  1  read select: 1 = HI, 0 = LO.
- busy  output  1  an operation is in progress.
- HiLoData  output  32  combinational read of HI or LO, chosen by `hilo_sel`.

## Operation

- State machine with two states, IDLE and BUSY.
- Internal state: a counter of width clog2(max(MULT_CYCLES, DIV_CYCLES)) + 1, plus pending registers `hi_nxt` and `lo_nxt`.
- IDLE, `start` = 1, op is MULT or MULTU:
  - Full 64-bit product, signed or unsigned.
  - `hi_nxt` = product[63:32], `lo_nxt` = product[31:0].
  - Counter is loaded with MULT_CYCLES; go to BUSY.
- IDLE, `start` = 1, op is DIV or DIVU:
  - `lo_nxt` = quotient truncated toward zero; `hi_nxt` = remainder, with the sign of the dividend.
  - Signed 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
  - Counter is loaded with DIV_CYCLES; go to BUSY.
- Divide by zero (B = 0): `hi_nxt` and `lo_nxt` take the current HI and LO, so both are unchanged at commit. The full DIV_CYCLES busy period still applies.
- IDLE, `start` = 1, op is MTHI or MTLO: HI (or LO) takes A at that edge. `busy` stays 0.
- BUSY: the counter decrements every cycle. In the cycle the counter equals 1, the next edge commits HI ← `hi_nxt`, LO ← `lo_nxt`, and the FSM returns to IDLE.
- `start` while BUSY is ignored completely: no state change, no restart. The stall logic must not issue such a request.
- Undefined `md_op` codes with `start` = 1 are ignored.
- `HiLoData` always shows the committed HI/LO, never the pending values. While BUSY it shows the old values.

## Timing

- Reset value of every output and register: `busy` = 0, HI = 0, LO = 0, counter = 0, pending registers = 0, state = IDLE. `HiLoData` = 0 while reset is held.
- Reset asserted mid-operation: the pending result is discarded immediately (asynchronously), and HI/LO are cleared.
- Multiply or divide accepted at edge k:
  - `busy` = 1 during cycles k+1 through k+N (N = MULT_CYCLES or DIV_CYCLES).
  - HI/LO are updated at the edge that ends cycle k+N.
  - `busy` = 0 and the new value is visible on `HiLoData` in cycle k+N+1.
- A new `start` is accepted in cycle k+N+1 (back-to-back after completion).
- MTHI/MTLO accepted at edge k: visible on `HiLoData` in cycle k+1.
- `busy` is a registered output. The hazard unit ORs it with decoded `start` itself.

## Structure

- Shared package holds the `md_op` encoding constants: MD_MULT = 0, MD_MULTU = 1, MD_DIV = 2, MD_DIVU = 3, MD_MTHI = 4, MD_MTLO = 5.
- The package also holds the default cycle counts, reused by the hazard unit.
- Single module, no sub-module. Arithmetic is computed combinationally at accept time; the counter models the latency.

## Test plan

- Reset, then a read: `HiLoData` = 0 for both `hilo_sel` values; `busy` = 0.
- MULT A = 0xFFFFFFFF, B = 2:
  - `busy` high for exactly 5 cycles.
  - Then HI = 0xFFFFFFFF, LO = 0xFFFFFFFE.
  - Repeat as MULTU: HI = 0x00000001, LO = 0xFFFFFFFE.
- DIV A = 0xFFFFFFF9 (−7), B = 2:
  - 10 busy cycles.
  - Then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - Repeat as DIVU A = 7, B = 2: LO = 3, HI = 1.
- MTHI A = 0x12345678, then DIV with B = 0:
  - HI reads 0x12345678 the next cycle.
  - After 10 busy cycles, HI = 0x12345678 and LO = 0 (unchanged).
- MULT in progress, second `start` (DIVU 100/3) at cycle 2 of BUSY: ignored. `busy` still drops after the original 5 cycles, and the MULT result is committed.
- Reset asserted at cycle 3 of a DIV:
  - `busy`, HI and LO read 0 immediately.
  - After release, a fresh MTLO 0xA5A5A5A5 reads back 0xA5A5A5A5.
